// File: rtl/adder_ring_measure_ctrl.sv
// Ring-oscillator delay measurement sequencer for the instrumented adder.
// Loads operands and masks, releases the ring, and counts chain_out edges over a window.
module adder_ring_measure_ctrl #(
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    // window counter width; defaults to CNT_W, may be widened when CNT_W is small
    parameter int WIN_W         = CNT_W
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_a,
    input  logic [WIDTH-1:0] cfg_b,
    input  logic [WIDTH-1:0] cfg_ring_mask,
    input  logic [WIDTH-1:0] cfg_ext_mask,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             chain_out,
    output logic [WIDTH-1:0] a_input,
    output logic [WIDTH-1:0] b_input,
    output logic [WIDTH-1:0] a_input_ring_bit_b,
    output logic [WIDTH-1:0] a_input_ext_bit_b,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] edge_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_t;

    localparam int ST_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [ST_W-1:0]  SETTLE_LD = ST_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t                 state_q;
    logic [WIDTH-1:0]       a_q, b_q, ring_q, ext_q, ring_mask_q;
    logic [WIN_W-1:0]       win_q;
    logic [ST_W-1:0]        settle_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q, done_q, ovf_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_d;
    logic [WIN_W-1:0]       win_ld_d;

    // Edge detect on the synchronized ring output and window length clamp (0 means 1)
    always_comb begin
        rise_d   = sync_q[SYNC_STAGES-1] & ~prev_q;
        win_ld_d = (cfg_window == '0) ? WIN_W'(1) : cfg_window;
    end

    // Synchronizer runs in every state so prev is valid when the window opens
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], chain_out};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Measurement sequencer with registered outputs; abort overrides any active state
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ring_q      <= '1;
            ext_q       <= '1;
            ring_mask_q <= '0;
            win_q       <= '0;
            settle_q    <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (abort && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            ring_q  <= '1;
            ext_q   <= '1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        a_q         <= cfg_a;
                        b_q         <= cfg_b;
                        ext_q       <= ~cfg_ext_mask;
                        ring_mask_q <= cfg_ring_mask;
                        win_q       <= win_ld_d;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    ring_q   <= ~ring_mask_q;
                    settle_q <= SETTLE_LD;
                    state_q  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q <= ST_W'(1)) begin
                        state_q <= S_MEASURE;
                    end else begin
                        settle_q <= settle_q - ST_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (rise_d) begin
                        if (cnt_q == CNT_MAX) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    if (win_q == WIN_W'(1)) begin
                        ring_q  <= '1;
                        ext_q   <= '1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        win_q <= win_q - WIN_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign a_input            = a_q;
    assign b_input            = b_q;
    assign a_input_ring_bit_b = ring_q;
    assign a_input_ext_bit_b  = ext_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign overflow           = ovf_q;
    assign edge_count         = cnt_q;

endmodule

// File: tb/tb_adder_ring_measure_ctrl.sv
// Bench for adder_ring_measure_ctrl: cycle model of the measurement timeline
// plus directed runs covering window edges, abort, window 0, reset and overflow.
module tb_adder_ring_measure_ctrl;

    localparam int S  = 4;
    localparam int SY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, chain;
    logic [31:0] cfg_a, cfg_b, cfg_ring, cfg_ext, cfg_window;
    logic [31:0] a_in, b_in, ring_b, ext_b, cnt;
    logic        busy, done, ovf;

    logic        start2, chain2;
    logic [7:0]  cfg_window2;
    logic [7:0]  a2, b2, ring2, ext2;
    logic [3:0]  cnt2;
    logic        busy2, done2, ovf2;

    always #5 clk = ~clk;

    adder_ring_measure_ctrl #(
        .WIDTH(32), .CNT_W(32), .SETTLE_CYCLES(S), .SYNC_STAGES(SY)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_ring_mask(cfg_ring),
        .cfg_ext_mask(cfg_ext), .cfg_window(cfg_window), .chain_out(chain),
        .a_input(a_in), .b_input(b_in), .a_input_ring_bit_b(ring_b),
        .a_input_ext_bit_b(ext_b), .busy(busy), .done(done),
        .overflow(ovf), .edge_count(cnt)
    );

    adder_ring_measure_ctrl #(
        .WIDTH(8), .CNT_W(4), .SETTLE_CYCLES(S), .SYNC_STAGES(SY), .WIN_W(8)
    ) dut2 (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start2), .abort(1'b0),
        .cfg_a(8'd7), .cfg_b(8'd9), .cfg_ring_mask(8'h01),
        .cfg_ext_mask(8'h00), .cfg_window(cfg_window2), .chain_out(chain2),
        .a_input(a2), .b_input(b2), .a_input_ring_bit_b(ring2),
        .a_input_ext_bit_b(ext2), .busy(busy2), .done(done2),
        .overflow(ovf2), .edge_count(cnt2)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // model state: one measurement run described by its start cycle
    bit          samp [0:4095];
    bit          have_run = 0;
    bit          aborted  = 0;
    int          T, A, W;
    logic [31:0] m_a, m_b, m_ring, m_ext;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // rising edges of chain_out that land inside the window before cycle n
    function automatic longint raw_edges(input int n);
        int     lo, hi;
        longint c;
        lo = T + 2 + S;
        hi = T + 1 + S + W;
        if (aborted && A - 1 < hi) hi = A - 1;
        if (n - 1 < hi) hi = n - 1;
        c = 0;
        for (int d = lo; d <= hi; d++)
            if (d - SY >= 1 && samp[d-SY] && !samp[d-SY-1]) c++;
        return c;
    endfunction

    // model reacts to the inputs sampled at each rising edge
    always @(posedge clk) begin
        int rel, e;
        bit idle;
        samp[cyc] = chain;
        if (rst_n) begin
            rel  = cyc - T;
            e    = 1 + S + W;
            idle = !have_run || (aborted && cyc > A) || (!aborted && rel >= e + 2);
            if (have_run && !aborted && abort && rel >= 1 && rel <= e) begin
                aborted = 1;
                A       = cyc;
            end else if (idle && start && !abort) begin
                have_run = 1;
                aborted  = 0;
                T        = cyc;
                W        = (cfg_window == 0) ? 1 : int'(cfg_window);
                m_a      = cfg_a;
                m_b      = cfg_b;
                m_ring   = cfg_ring;
                m_ext    = cfg_ext;
            end
        end
        cyc++;
    end

    // per-cycle comparison of every output against the model
    always begin
        int          rel, e;
        longint      raw;
        bit          act, e_done, e_ovf;
        logic [31:0] e_a, e_b, e_ring, e_ext, e_cnt;
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (!have_run) begin
                act = 0; e_done = 0; e_ovf = 0;
                e_a = 0; e_b = 0; e_ring = '1; e_ext = '1; e_cnt = 0;
            end else begin
                rel    = cyc - T;
                e      = 1 + S + W;
                act    = rel <= e && !(aborted && cyc > A);
                e_done = !aborted && rel >= e + 1;
                e_a    = m_a;
                e_b    = m_b;
                e_ext  = act ? ~m_ext : '1;
                e_ring = (act && rel >= 2) ? ~m_ring : '1;
                raw    = raw_edges(cyc);
                e_ovf  = raw > 64'hFFFF_FFFF;
                e_cnt  = e_ovf ? 32'hFFFF_FFFF : raw[31:0];
            end
            check("busy", busy, act);
            check("done", done, e_done);
            check("ovf", ovf, e_ovf);
            check("a_input", a_in, e_a);
            check("b_input", b_in, e_b);
            check("ring_bit_b", ring_b, e_ring);
            check("ext_bit_b", ext_b, e_ext);
            check("edge_count", cnt, e_cnt);
        end
    end

    // advance to cycle c; chain either toggles with period per or pulses at k0..k2
    task automatic step_to(input int c, input int t, input int per,
                           input int k0, input int k1, input int k2);
        while (cyc < c) begin
            @(negedge clk);
            if (per > 0) chain = (((cyc - t) / per) % 2) == 1;
            else chain = (cyc == t + k0) || (cyc == t + k1) || (cyc == t + k2);
        end
    endtask

    task automatic do_start(output int t);
        @(negedge clk);
        start = 1;
        t     = cyc;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        int t;
        bit got;
        rst_n = 0; start = 0; abort = 0; chain = 0;
        start2 = 0; chain2 = 0; cfg_window2 = 0;
        cfg_a = 5; cfg_b = 3; cfg_ring = 32'h0000_1000;
        cfg_ext = 32'h0000_0002; cfg_window = 20;
        repeat (3) @(negedge clk);
        check("rst_ring", ring_b, 32'hFFFF_FFFF);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // basic run, chain toggling every 4 cycles
        do_start(t);
        check("basic_busy_t1", busy, 1);
        step_to(t + 3, t, 4, 0, 0, 0);
        cfg_a = 99; cfg_ring = 0;
        step_to(t + 10, t, 4, 0, 0, 0);
        check("basic_ring", ring_b, 32'hFFFF_EFFF);
        step_to(t + 25, t, 4, 0, 0, 0);
        check("basic_done_early", done, 0);
        step_to(t + 26, t, 4, 0, 0, 0);
        check("basic_done", done, 1);
        check("basic_cnt", cnt, 3);
        check("basic_a", a_in, 5);
        step_to(t + 28, t, 4, 0, 0, 0);
        chain = 0;
        cfg_a = 5; cfg_ring = 32'h0000_1000;

        // edges exactly on the first and last window cycles count
        cfg_window = 10;
        do_start(t);
        step_to(t + 16, t, 0, 4, 13, -100);
        check("win_edges_in", cnt, 2);
        step_to(t + 18, t, 0, 4, 13, -100);

        // edges one cycle before and one after the window do not
        do_start(t);
        step_to(t + 16, t, 0, 3, 14, -100);
        check("win_edges_out", cnt, 0);
        check("win_out_done", done, 1);
        step_to(t + 18, t, 0, 3, 14, -100);

        // start and abort together: no measurement
        @(negedge clk);
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        check("collide_busy", busy, 0);
        check("collide_done", done, 1);

        // abort at window cycle 5 keeps the partial count
        cfg_window = 20;
        do_start(t);
        step_to(t + 10, t, 0, 4, 6, 12);
        abort = 1;
        step_to(t + 11, t, 0, 4, 6, 12);
        abort = 0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ring", ring_b, 32'hFFFF_FFFF);
        check("abort_cnt", cnt, 2);
        step_to(t + 20, t, 0, 4, 6, 12);

        // window 0 behaves as a one-cycle window, then restart clears done
        cfg_window = 0;
        do_start(t);
        step_to(t + 6, t, 0, 4, -100, -100);
        check("w0_done_early", done, 0);
        step_to(t + 7, t, 0, 4, -100, -100);
        check("w0_done", done, 1);
        check("w0_cnt", cnt, 1);
        step_to(t + 9, t, 0, 4, -100, -100);
        cfg_window = 5;
        start = 1;
        step_to(t + 10, t, 0, 4, -100, -100);
        start = 0;
        check("restart_done", done, 0);
        check("restart_cnt", cnt, 0);
        check("restart_busy", busy, 1);
        step_to(t + 22, t, 0, 4, -100, -100);

        // asynchronous reset in the middle of a window
        cfg_window = 20;
        do_start(t);
        step_to(t + 12, t, 2, 0, 0, 0);
        rst_n = 0;
        have_run = 0;
        #1;
        check("mid_rst_ring", ring_b, 32'hFFFF_FFFF);
        check("mid_rst_ext", ext_b, 32'hFFFF_FFFF);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cnt", cnt, 0);
        chain = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 0);

        // 4-bit counter saturates with a fast ring over a 40-cycle window
        @(negedge clk);
        cfg_window2 = 40;
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            chain2 = ~chain2;
            if (done2) got = 1;
        end
        check("ovf_done_seen", got, 1);
        check("ovf_cnt", cnt2, 15);
        check("ovf_flag", ovf2, 1);
        chain2 = 0;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
